// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one overlapping "1011" detector among
// NREQ requesters; each granted frame is shifted MSB-first and its match count returned.
module seq_detect_sched #(
    parameter int NREQ    = 4,
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*FRAME_W-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [CNT_W-1:0]          rsp_count,
    input  logic                      rsp_ready,
    output logic                      busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam int BC_W = $clog2(FRAME_W);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // req_ready is a combinational one-hot grant, only ever raised in IDLE.
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_REPORT} state_t;
    typedef enum logic [1:0] {D_S0, D_S1, D_S10, D_S101} det_t;

    state_t             state_q, state_d;
    det_t               det_q, det_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;

    logic               arb_found;
    logic [ID_W-1:0]    arb_gnt;
    logic [ID_W:0]      cand;
    logic               bit_in;
    logic               match;
    det_t               det_nx;

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        arb_found = 1'b0;
        arb_gnt   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!arb_found && req_valid[cand[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_gnt   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bit_in = shreg_q[FRAME_W-1];
        match  = 1'b0;
        det_nx = D_S0;
        case (det_q)
            D_S0:    det_nx = bit_in ? D_S1 : D_S0;
            D_S1:    det_nx = bit_in ? D_S1 : D_S10;
            D_S10:   det_nx = bit_in ? D_S101 : D_S0;
            D_S101: begin
                match  = bit_in;
                det_nx = bit_in ? D_S1 : D_S10;
            end
            default: det_nx = D_S0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        det_d       = det_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        count_d     = count_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found && !reset) begin
                    req_ready = NREQ'(1) << arb_gnt;
                    shreg_d   = req_data[int'(arb_gnt)*FRAME_W +: FRAME_W];
                    gnt_d     = arb_gnt;
                    count_d   = '0;
                    det_d     = D_S0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_d     = det_nx;
                shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (match && (count_q != '1)) begin
                    count_d = count_q + CNT_W'(1);
                end
                // The count including the final bit is captured straight into the response.
                if (bit_cnt_q == BC_W'(FRAME_W-1)) begin
                    bit_cnt_d   = '0;
                    rsp_id_d    = gnt_q;
                    rsp_count_d = count_d;
                    state_d     = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (rsp_ready) begin
                    rr_ptr_d = (gnt_q == ID_W'(NREQ-1)) ? '0 : gnt_q + ID_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            det_q       <= D_S0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            count_q     <= '0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            det_q       <= det_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            count_q     <= count_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign rsp_valid = (state_q == ST_REPORT);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;

endmodule
